gen_skid_buf: RTL and testbench
===============================

GEN_SKID_BUF -- requirements
Module: gen_skid_buf

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning payload width in bits.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 Port flush SHALL be an input, 1 bit wide: synchronous discard of all held beats (see REQ-022).
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the producer offers din.
REQ-006 Port din SHALL be an input, DW bits wide: the producer payload.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the buffer accepts din this cycle.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: dout holds a valid beat.
REQ-009 Port dout SHALL be an output, DW bits wide: the consumer payload.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer takes dout this cycle.

Function
REQ-011 An input beat SHALL transfer on a rising edge where in_valid=1 and in_ready=1 (in-fire); an output beat SHALL transfer where out_valid=1 and out_ready=1 (out-fire).
REQ-012 Storage SHALL be two DW-bit registers, main (drives dout) and skid, plus a state machine with states EMPTY, ONE and FULL.
REQ-013 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY, decoded from registered state only.
REQ-014 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and forced to 0 while flush=1 when the flush feature is compiled in; there SHALL be no combinational path from out_ready to in_ready.
REQ-015 In EMPTY, an in-fire SHALL load main with din and move the state to ONE.
REQ-016 In ONE with in-fire and out-fire together, main SHALL load din and the state SHALL remain ONE.
REQ-017 In ONE with in-fire only, skid SHALL load din and the state SHALL move to FULL.
REQ-018 In ONE with out-fire only, the state SHALL move to EMPTY.
REQ-019 In FULL, an out-fire SHALL copy skid into main and move the state to ONE; with no out-fire, the state SHALL not change.
REQ-020 Latency SHALL be 1 cycle from in-fire to out_valid; sustained throughput SHALL be 1 beat per cycle when out_ready is held at 1; beats SHALL leave in acceptance order, with no loss or duplication.
REQ-021 While out_valid=1 and out_ready=0, dout SHALL hold its value stable.
REQ-022 flush SHALL take priority over both handshakes: the state SHALL go to EMPTY and main and skid SHALL clear to 0 on the next edge.

Reset
REQ-023 When rst=0, the block SHALL immediately, without waiting for a clock edge, set state to EMPTY, main and skid to 0, out_valid to 0, dout to 0 and in_ready to 1.
REQ-024 A reset asserted mid-transfer SHALL discard held beats; the first in-fire after rst rises SHALL behave as from EMPTY.

Configuration
REQ-025 Macro GEN_SKID_FLUSH_EN SHALL select the flush feature; when defined, flush SHALL behave per REQ-014 and REQ-022.
REQ-026 When GEN_SKID_FLUSH_EN is undefined, the flush port SHALL still exist but SHALL be ignored, with no logic depending on it.

Verification
REQ-027 With out_ready=1, drive din=1,2,3,4 on consecutive cycles -> dout=1,2,3,4 one cycle later each, in_ready held at 1.
REQ-028 With out_ready=0, drive din=0xA then 0xB -> state FULL, in_ready=0, dout=0xA stable; then out_ready=1 for 2 cycles -> dout=0xA, then 0xB, then out_valid=0.
REQ-029 In FULL, raise out_ready and in_valid together -> only out-fire occurs; in_ready returns to 1 the next cycle and the pending beat is accepted then.
REQ-030 With GEN_SKID_FLUSH_EN defined, in FULL pulse flush with in_valid=1 and din=0x5 -> next cycle out_valid=0, dout=0, and 0x5 not accepted; with the macro undefined, the same flush has no effect.
REQ-031 Assert rst=0 mid-stream between clock edges -> out_valid=0 and dout=0 immediately; after release, din=0x7 -> dout=0x7 one cycle later.
REQ-032 Random valid/ready stress of at least 10k beats -> output sequence equals input sequence, and dout never changes while stalled.

Source files
------------

// File: rtl/gen_skid_buf.sv
// Two-entry skid buffer (main + skid registers) with a valid/ready handshake on both sides.
// Optional synchronous flush is compiled in when GEN_SKID_FLUSH_EN is defined.
module gen_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] din,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] dout,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic [DW-1:0] w_main_nxt;
  logic [DW-1:0] w_skid_nxt;
  logic          w_flush;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_in_fire;
  logic          w_out_fire;

`ifdef GEN_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  // The port is kept for a uniform interface; nothing in the datapath sees it.
  logic w_flush_unused;
  assign w_flush_unused = flush;
  assign w_flush        = 1'b0;
`endif

  // in_ready depends only on registered state and flush, never on out_ready.
  assign w_in_ready  = (r_state != ST_FULL) && !w_flush;
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = out_ready && w_out_valid;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign dout      = r_main;

  // Next-state and storage update; flush overrides both handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (w_flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = {DW{1'b0}};
      w_skid_nxt  = {DW{1'b0}};
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = din;
            w_state_nxt = ST_ONE;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt  = din;
            w_state_nxt = ST_ONE;
          end else if (w_in_fire) begin
            w_skid_nxt  = din;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_ONE;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = {DW{1'b0}};
          w_skid_nxt  = {DW{1'b0}};
        end
      endcase
    end
  end

  // State and payload registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_main  <= {DW{1'b0}};
      r_skid  <= {DW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

// File: tb/tb_gen_skid_buf.sv
// Self-checking bench for gen_skid_buf: directed vector table, flush/reset sequences
// and a randomized valid/ready stress against a two-entry queue model.
module tb_gen_skid_buf;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] din;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] dout;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  gen_skid_buf #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .din       (din),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .dout      (dout),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_dout;
    logic          chk_d;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] prev_dout;
    logic          prev_stall;
    logic          in_fire;
    logic          out_fire;
    int            beats;
    int            cyc;

    // {flush, in_valid, din, out_ready, exp in_ready, exp out_valid, exp dout, check dout}
    vecs[0]  = '{1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hB, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 32'hC, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 32'hC, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'hE, 1'b1, 1'b1, 1'b1, 32'hD, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'hE, 1'b0, 1'b0, 1'b1, 32'hD, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hE, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_dout", dout, 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; din = vecs[i].d; out_ready = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      if (vecs[i].chk_d) chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
    end

    // Flush while FULL, with a competing input beat.
    in_valid = 1'b1; din = 32'h11; out_ready = 1'b0; step();
    din = 32'h22; step();
    chk("pre_flush_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; din = 32'h5; step();
    flush = 1'b0; in_valid = 1'b0;
`ifdef GEN_SKID_FLUSH_EN
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_dout", dout, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; step();
    chk("flush_no_accept", {31'd0, out_valid}, 32'd0);
`else
    chk("noflush_out_valid", {31'd0, out_valid}, 32'd1);
    chk("noflush_dout", dout, 32'h11);
    chk("noflush_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; step();
    chk("noflush_drain1", dout, 32'h22);
    step();
    chk("noflush_drain2", {31'd0, out_valid}, 32'd0);
`endif

    // Asynchronous reset between edges while holding a beat.
    in_valid = 1'b1; din = 32'h33; out_ready = 1'b0; step();
    chk("pre_rst_dout", dout, 32'h33);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_dout", dout, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #2 rst = 1'b1;
    step();
    in_valid = 1'b1; din = 32'h7; out_ready = 1'b1; step();
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_dout", dout, 32'h7);
    in_valid = 1'b0; step();
    chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

    // Random stress against a two-entry FIFO model.
    beats = 0; cyc = 0; prev_stall = 1'b0; prev_dout = '0;
    while (beats < 10000 && cyc < 30000 && failures < 50) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      din       = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      chk("stress_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
      chk("stress_out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      if (q.size() > 0) chk("stress_dout", dout, q[0]);
      if (prev_stall) chk("stress_stall_stable", dout, prev_dout);
      in_fire    = in_valid && (q.size() < 2);
      out_fire   = out_ready && (q.size() > 0);
      prev_stall = (q.size() > 0) && !out_ready;
      prev_dout  = dout;
      if (out_fire) begin
        void'(q.pop_front());
        beats++;
      end
      if (in_fire) q.push_back(din);
      step();
      cyc++;
    end
    chk("stress_beats_done", beats, 32'd10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
